ofmap_accumulator: RTL

//  Output stage directly after the systolic datapath. Takes the skewed per-column partial sums (of_data).

---
 rtl/ofmap_accumulator.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ofmap_accumulator.sv
// Output stage behind the systolic array: deskews per-column partial sums into rows,
// accumulates them across K-tiles in a ROWS x COLS bank, then drains requantized rows.

module ofmap_lane #(
    parameter int ROWS  = 4,
    parameter int P_W   = 16,
    parameter int ACC_W = 32,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic             first,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [P_W-1:0]   d,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [OUT_W-1:0] q
);
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND  = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : (ACC_W+1)'(0);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (OUT_W-1)) - 1);

    logic [ACC_W-1:0] col [ROWS];
    logic [ACC_W-1:0] acc;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] r;

    // Bank is deliberately not reset; first_tile overwrites stale contents.
    always_ff @(posedge clk) begin
        if (we)
            col[wr_ptr] <= first ? ACC_W'($signed(d)) : col[wr_ptr] + ACC_W'($signed(d));
    end

    assign acc = col[rd_ptr];

    // One extra bit keeps the rounding add from overflowing before the shift.
    always_comb begin
        sum = $signed({acc[ACC_W-1], acc}) + RND;
        r   = sum >>> SHIFT;
        if (r < 0)
            q = '0;
        else if (r > MAXV)
            q = OUT_W'(MAXV);
        else
            q = r[OUT_W-1:0];
    end
endmodule

module ofmap_accumulator #(
    parameter int COLS  = 4,
    parameter int ROWS  = 4,
    parameter int P_W   = 16,
    parameter int ACC_W = 32,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tile_start,
    input  logic                       first_tile,
    input  logic                       last_tile,
    input  logic [COLS-1:0]            of_valid,
    input  logic [COLS-1:0][P_W-1:0]   of_data,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [COLS-1:0][OUT_W-1:0] o_data,
    output logic                       o_last,
    output logic                       busy,
    output logic                       err
);
    localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                     state;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic                       first_q;
    logic                       last_q;
    logic [COLS-1:0]            al_v;
    logic [COLS-1:0][P_W-1:0]   al_d;
    logic [COLS-1:0][OUT_W-1:0] q;
    logic                       row_v;
    logic                       skew_err;
    logic                       we;
    logic                       accept;

    // Column c is late by c cycles, so it gets COLS-1-c stages to line up with the last column.
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign al_v[c] = of_valid[c];
            assign al_d[c] = of_data[c];
        end else begin : g_dly
            logic [D-1:0]          vld_pipe;
            logic [D-1:0][P_W-1:0] dat_pipe;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else begin
                    vld_pipe[0] <= of_valid[c];
                    dat_pipe[0] <= of_data[c];
                    for (int i = 1; i < D; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        dat_pipe[i] <= dat_pipe[i-1];
                    end
                end
            end
            assign al_v[c] = vld_pipe[D-1];
            assign al_d[c] = dat_pipe[D-1];
        end
    end

    assign row_v    = al_v[0];
    assign skew_err = |(al_v ^ {COLS{row_v}});
    assign we       = (state == ACCUM) && row_v;
    assign o_valid  = (state == DRAIN);
    assign busy     = (state != IDLE);
    assign accept   = o_valid && o_ready;
    assign o_last   = o_valid && (rd_ptr == LAST);
    assign o_data   = o_valid ? q : '0;

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        ofmap_lane #(
            .ROWS(ROWS), .P_W(P_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .PTR_W(PTR_W)
        ) u_lane (
            .clk(clk), .we(we), .first(first_q), .wr_ptr(wr_ptr),
            .d(al_d[c]), .rd_ptr(rd_ptr), .q(q[c])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (skew_err)
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (row_v)
                        err <= 1'b1;
                    if (tile_start) begin
                        state   <= ACCUM;
                        first_q <= first_tile;
                        last_q  <= last_tile;
                        wr_ptr  <= '0;
                    end
                end
                ACCUM: begin
                    if (tile_start)
                        err <= 1'b1;
                    if (row_v) begin
                        if (wr_ptr == LAST) begin
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                            state  <= last_q ? DRAIN : IDLE;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Includes a tile_start coinciding with the final accept.
                    if (tile_start || row_v)
                        err <= 1'b1;
                    if (accept) begin
                        if (rd_ptr == LAST) begin
                            rd_ptr <= '0;
                            state  <= IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
